// File: rtl/i2c_cpu_regif.sv
// CPU register bank, TX byte FIFO, RX holding register and transfer sequencer
// sitting between the CPU bus and the i2c master core.
module i2c_cpu_regif #(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       cpu_addr,
    input  logic [DW-1:0]    cpu_wdata,
    input  logic             cpu_r_w,
    input  logic             cpu_en,
    output logic [DW-1:0]    cpu_rdata,
    output logic             irq,
    output logic             core_go,
    output logic [7:0]       core_sla,
    output logic [LEN_W-1:0] core_len,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_pop,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             core_done,
    input  logic             core_success
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

    state_t           state;
    logic [7:0]       slave_reg;
    logic [LEN_W-1:0] len_reg;
    logic             irq_en;
    logic             done, success, ovf, err, rx_flag;
    logic [7:0]       rx_hold;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      count;
    logic [DW-1:0]    rdata_next;

    logic wr, rd, idle, full, empty;
    logic wr_slave, wr_tx, wr_ctrl, wr_len, status_rd, rxdata_rd;
    logic go_req, flush_req, go_ok, err_set, ovf_set, push_ok, pop_ok, flush;

    assign wr        = cpu_en & ~cpu_r_w;
    assign rd        = cpu_en & cpu_r_w;
    assign idle      = (state == IDLE);
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign wr_slave  = wr & (cpu_addr == 3'd0);
    assign wr_tx     = wr & (cpu_addr == 3'd1);
    assign wr_ctrl   = wr & (cpu_addr == 3'd2);
    assign wr_len    = wr & (cpu_addr == 3'd5);
    assign status_rd = rd & (cpu_addr == 3'd3);
    assign rxdata_rd = rd & (cpu_addr == 3'd4);
    assign go_req    = wr_ctrl & cpu_wdata[0];
    assign flush_req = wr_ctrl & cpu_wdata[2];

    // A read transfer needs no TX bytes; a write transfer needs at least one queued.
    assign go_ok   = idle & go_req & (len_reg != '0) & (slave_reg[7] | ~empty);
    assign err_set = (idle & go_req & ~go_ok)
                   | (~idle & (wr_slave | wr_len | go_req | flush_req));
    assign ovf_set = (wr_tx & full) | (rx_valid & rx_flag);
    assign push_ok = wr_tx & ~full;
    assign pop_ok  = tx_pop & ~empty;
    assign flush   = idle & flush_req;

    assign tx_data  = mem[rd_ptr];
    assign tx_valid = ~empty;
    assign irq      = irq_en & done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            core_go  <= 1'b0;
            core_sla <= 8'h00;
            core_len <= '0;
        end else begin
            core_go <= 1'b0;
            case (state)
                IDLE: if (go_ok) begin
                    state    <= START;
                    core_go  <= 1'b1;
                    core_sla <= {slave_reg[6:0], slave_reg[7]};
                    core_len <= len_reg;
                end
                START:   state <= BUSY;
                BUSY:    if (core_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slave_reg <= 8'h00;
            len_reg   <= '0;
            irq_en    <= 1'b0;
            done      <= 1'b0;
            success   <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            rx_flag   <= 1'b0;
            rx_hold   <= 8'h00;
        end else begin
            if (wr_slave & idle) slave_reg <= cpu_wdata[7:0];
            if (wr_len & idle)   len_reg   <= cpu_wdata[LEN_W-1:0];
            if (wr_ctrl)         irq_en    <= cpu_wdata[1];
            if (state == START) begin
                done    <= 1'b0;
                success <= 1'b0;
            end else if ((state == BUSY) & core_done) begin
                done    <= 1'b1;
                success <= core_success;
            end else if (status_rd) begin
                done    <= 1'b0;
            end
            // Read-to-clear loses against a set on the same edge.
            ovf <= ovf_set | (ovf & ~status_rd);
            err <= err_set | (err & ~status_rd);
            if (rx_valid) begin
                rx_hold <= rx_data;
                rx_flag <= 1'b1;
            end else if (rxdata_rd) begin
                rx_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok & ~pop_ok)      count <= count + 1'b1;
            else if (pop_ok & ~push_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= cpu_wdata[7:0];
    end

    always_comb begin
        rdata_next = '0;
        case (cpu_addr)
            3'd0: rdata_next[7:0] = slave_reg;
            3'd2: rdata_next[1]   = irq_en;
            3'd3: rdata_next[7:0] = {err, ovf, rx_flag, empty, full, ~idle, success, done};
            3'd4: rdata_next[7:0] = rx_hold;
            3'd5: rdata_next[LEN_W-1:0] = len_reg;
            default: rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     cpu_rdata <= '0;
        else if (rd) cpu_rdata <= rdata_next;
    end

endmodule
